// File: rtl/keypad_pkg.sv
// Shared types, keymap and row-decode helper for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } row_hit_t;

    // Indexed [row][col]
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Exactly one row low is a key; all-high or several low rows are rejected.
    function automatic row_hit_t onehot_low_idx(input logic [3:0] rows);
        row_hit_t hit;
        hit.valid = 1'b0;
        hit.idx   = 2'd0;
        case (rows)
            4'b1110: begin hit.valid = 1'b1; hit.idx = 2'd0; end
            4'b1101: begin hit.valid = 1'b1; hit.idx = 2'd1; end
            4'b1011: begin hit.valid = 1'b1; hit.idx = 2'd2; end
            4'b0111: begin hit.valid = 1'b1; hit.idx = 2'd3; end
            default: begin hit.valid = 1'b0; hit.idx = 2'd0; end
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Generic two-flop synchronizer; resets to all-ones to match idle pulled-up inputs.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column rotation, press/release debounce, hex encode.
//
//  state    | meaning
//  SCAN     | rotating columns, looking for a single low row at each dwell sample
//  DEBOUNCE | column frozen, counting consecutive samples matching the latched row
//  HELD     | key accepted, column frozen, counting consecutive all-high samples
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 40000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_SCANS);

    logic [3:0]    w_rows_s;
    logic          w_sample;
    row_hit_t      w_hit;

    logic [DW-1:0] r_dwell;
    state_t        r_state,   w_state_nxt;
    logic [1:0]    r_col_idx, w_col_idx_nxt;
    logic [1:0]    r_row,     w_row_nxt;
    logic [CW-1:0] r_deb,     w_deb_nxt;
    logic [CW-1:0] r_rel,     w_rel_nxt;
    logic [3:0]    r_key,     w_key_nxt;
    logic          r_valid,   w_valid_nxt;
    logic          r_held,    w_held_nxt;
    logic [CW-1:0] w_deb_inc;
    logic [CW-1:0] w_rel_inc;

    sync2 #(.WIDTH(4)) u_sync_rows (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (rows),
        .o_q     (w_rows_s)
    );

    assign w_sample  = (r_dwell == DWELL_LAST);
    assign w_hit     = onehot_low_idx(w_rows_s);
    assign w_deb_inc = (r_deb >= CNT_TARGET) ? CNT_TARGET : r_deb + 1'b1;
    assign w_rel_inc = (r_rel >= CNT_TARGET) ? CNT_TARGET : r_rel + 1'b1;

    // Dwell counter: wraps every SCAN_DIV cycles, last count is the sample point
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dwell <= '0;
        end else if (w_sample) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    // State, column, counters and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= SCAN;
            r_col_idx <= 2'd0;
            r_row     <= 2'd0;
            r_deb     <= '0;
            r_rel     <= '0;
            r_key     <= 4'h0;
            r_valid   <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_col_idx <= w_col_idx_nxt;
            r_row     <= w_row_nxt;
            r_deb     <= w_deb_nxt;
            r_rel     <= w_rel_nxt;
            r_key     <= w_key_nxt;
            r_valid   <= w_valid_nxt;
            r_held    <= w_held_nxt;
        end
    end

    // Next-state and output decode; only acts on dwell sample cycles
    always_comb begin
        w_state_nxt   = r_state;
        w_col_idx_nxt = r_col_idx;
        w_row_nxt     = r_row;
        w_deb_nxt     = r_deb;
        w_rel_nxt     = r_rel;
        w_key_nxt     = r_key;
        w_valid_nxt   = 1'b0;
        w_held_nxt    = r_held;

        if (w_sample) begin
            case (r_state)
                SCAN: begin
                    if (w_hit.valid) begin
                        w_row_nxt = w_hit.idx;
                        // A single required sample accepts on the first sighting
                        if (CNT_TARGET == CW'(1)) begin
                            w_deb_nxt   = CNT_TARGET;
                            w_rel_nxt   = '0;
                            w_key_nxt   = KEYMAP[w_hit.idx][r_col_idx];
                            w_valid_nxt = 1'b1;
                            w_held_nxt  = 1'b1;
                            w_state_nxt = HELD;
                        end else begin
                            w_deb_nxt   = CW'(1);
                            w_state_nxt = DEBOUNCE;
                        end
                    end else begin
                        w_col_idx_nxt = r_col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (w_hit.valid && (w_hit.idx == r_row)) begin
                        w_deb_nxt = w_deb_inc;
                        if (w_deb_inc == CNT_TARGET) begin
                            w_rel_nxt   = '0;
                            w_key_nxt   = KEYMAP[r_row][r_col_idx];
                            w_valid_nxt = 1'b1;
                            w_held_nxt  = 1'b1;
                            w_state_nxt = HELD;
                        end
                    end else begin
                        w_deb_nxt     = '0;
                        w_col_idx_nxt = r_col_idx + 2'd1;
                        w_state_nxt   = SCAN;
                    end
                end
                HELD: begin
                    if (w_rows_s == 4'hF) begin
                        if (w_rel_inc == CNT_TARGET) begin
                            w_rel_nxt     = '0;
                            w_deb_nxt     = '0;
                            w_held_nxt    = 1'b0;
                            w_col_idx_nxt = r_col_idx + 2'd1;
                            w_state_nxt   = SCAN;
                        end else begin
                            w_rel_nxt = w_rel_inc;
                        end
                    end else begin
                        w_rel_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = SCAN;
                end
            endcase
        end
    end

    assign cols      = ~(4'b0001 << r_col_idx);
    assign key       = r_key;
    assign key_valid = r_valid;
    assign key_held  = r_held;

endmodule
